// File: rtl/mem_store_checker.sv
// rtl/mem_store_checker.sv - in-order store-bus self-check monitor for the MIPS data memory
//
// Compares each store (memwrite/dataadr/writedata) seen while running against a
// table of expected (addr,data) pairs. Stores to an optional scratch address are
// skipped. The check ends in PASS, FAIL (first mismatching store captured) or
// TOUT (no matched store for TIMEOUT cycles; TIMEOUT=0 disables this).
//
// Optional feature macro: MSC_STORE_COUNT_EN
//   defined   - store_cnt counts every store seen while running, saturating
//   undefined - store_cnt is tied to zero
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   exp_we/exp_idx/exp_addr/exp_data   expected-table write port (IDLE only)
//   exp_cnt                     entries to check, latched on start, clamped to DEPTH
//   ign_en/ign_addr             scratch-address skip
//   start                       IDLE or terminal -> RUN
//   memwrite/dataadr/writedata  observed store bus
//   done, status                sticky finish flag; 00 run/idle, 01 pass, 10 mismatch, 11 timeout
//   match_idx                   entries matched so far
//   fail_addr/fail_data         first mismatching store
//   store_cnt                   stores seen while running
module mem_store_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    localparam int IDX_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [IDX_W-1:0]  exp_cnt,
    input  logic              ign_en,
    input  logic [ADDR_W-1:0] ign_addr,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic [1:0]        status,
    output logic [IDX_W-1:0]  match_idx,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [15:0]       store_cnt
);

    // Table storage index width; the array is rounded up to a power of two so
    // the index slice always matches the array range exactly.
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] DEPTH_V = IDX_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMO_V   = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TOUT
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   match_idx_q;
    logic [TMR_W-1:0]   timer_q;
    logic               done_q;
    logic [1:0]         status_q;
    logic [ADDR_W-1:0]  fail_addr_q;
    logic [DATA_W-1:0]  fail_data_q;

    logic [ADDR_W-1:0]  tbl_addr_q [0:(1<<AW)-1];
    logic [DATA_W-1:0]  tbl_data_q [0:(1<<AW)-1];

    logic [IDX_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   idx_inc_d;
    logic [TMR_W-1:0]   tmr_inc_d;
    logic               arm_d;
    logic               hit_exp_d;
    logic               hit_ign_d;
    logic               tmo_hit_d;

    always_comb begin
        cnt_d     = (exp_cnt > DEPTH_V) ? DEPTH_V : exp_cnt;
        idx_inc_d = match_idx_q + IDX_W'(1);
        tmr_inc_d = timer_q + TMR_W'(1);
        // Start is honoured in IDLE and in any terminal state (re-arm).
        arm_d     = start && (state_q != S_RUN);
        // Case equality: an X/Z address or data never counts as a hit, so an
        // undriven bus during a store falls through to the mismatch branch.
        hit_exp_d = (dataadr === tbl_addr_q[match_idx_q[AW-1:0]]) &&
                    (writedata === tbl_data_q[match_idx_q[AW-1:0]]);
        hit_ign_d = ign_en && (dataadr === ign_addr);
        tmo_hit_d = (TIMEOUT != 0) && (tmr_inc_d == TMO_V);
    end

    // Table has no reset; it must be reloaded after reset. Writes only land
    // in IDLE, including the start cycle, so they precede any check.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_IDLE && exp_we && exp_idx < DEPTH_V) begin
            tbl_addr_q[exp_idx[AW-1:0]] <= exp_addr;
            tbl_data_q[exp_idx[AW-1:0]] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            match_idx_q <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            status_q    <= 2'b00;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (arm_d) begin
            cnt_q       <= cnt_d;
            match_idx_q <= '0;
            timer_q     <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            if (cnt_d == '0) begin
                state_q  <= S_PASS;
                done_q   <= 1'b1;
                status_q <= 2'b01;
            end else begin
                state_q  <= S_RUN;
                done_q   <= 1'b0;
                status_q <= 2'b00;
            end
        end else if (state_q == S_RUN) begin
            timer_q <= tmr_inc_d;
            if (memwrite && hit_exp_d) begin
                // A match beats a timeout landing in the same cycle.
                match_idx_q <= idx_inc_d;
                timer_q     <= '0;
                if (idx_inc_d == cnt_q) begin
                    state_q  <= S_PASS;
                    done_q   <= 1'b1;
                    status_q <= 2'b01;
                end
            end else if (memwrite && !hit_ign_d) begin
                state_q     <= S_FAIL;
                done_q      <= 1'b1;
                status_q    <= 2'b10;
                fail_addr_q <= dataadr;
                fail_data_q <= writedata;
            end else if (tmo_hit_d) begin
                state_q  <= S_TOUT;
                done_q   <= 1'b1;
                status_q <= 2'b11;
            end
        end
    end

`ifdef MSC_STORE_COUNT_EN
    logic [15:0] store_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || arm_d) begin
            store_cnt_q <= '0;
        end else if (state_q == S_RUN && memwrite && store_cnt_q != 16'hFFFF) begin
            store_cnt_q <= store_cnt_q + 16'd1;
        end
    end

    assign store_cnt = store_cnt_q;
`else
    assign store_cnt = 16'd0;
`endif

    assign done      = done_q;
    assign status    = status_q;
    assign match_idx = match_idx_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_store_checker.sv
// tb/tb_mem_store_checker.sv - directed self-checking bench for mem_store_checker
module tb_mem_store_checker;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              exp_we;
    logic [IDX_W-1:0]  exp_idx;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [IDX_W-1:0]  exp_cnt;
    logic              ign_en;
    logic [ADDR_W-1:0] ign_addr;
    logic              start;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              done;
    logic [1:0]        status;
    logic [IDX_W-1:0]  match_idx;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;
    logic [15:0]       store_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_store_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .exp_we   (exp_we),
        .exp_idx  (exp_idx),
        .exp_addr (exp_addr),
        .exp_data (exp_data),
        .exp_cnt  (exp_cnt),
        .ign_en   (ign_en),
        .ign_addr (ign_addr),
        .start    (start),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .done     (done),
        .status   (status),
        .match_idx(match_idx),
        .fail_addr(fail_addr),
        .fail_data(fail_data),
        .store_cnt(store_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input int idx, input int a, input int d);
        exp_we   = 1'b1;
        exp_idx  = IDX_W'(idx);
        exp_addr = ADDR_W'(a);
        exp_data = DATA_W'(d);
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic do_start(input int cnt);
        start   = 1'b1;
        exp_cnt = IDX_W'(cnt);
        tick();
        start   = 1'b0;
    endtask

    task automatic store(input int a, input int d);
        memwrite  = 1'b1;
        dataadr   = ADDR_W'(a);
        writedata = DATA_W'(d);
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (status !== 2'b00) begin n_bad++; $display("FAIL reset_status got %0b want 00", status); end
        n_cmp++; if (match_idx !== 4'd0) begin n_bad++; $display("FAIL reset_match_idx got %0d want 0", match_idx); end
        n_cmp++; if (fail_addr !== 32'd0 || fail_data !== 32'd0) begin n_bad++; $display("FAIL reset_fail got %0h/%0h want 0/0", fail_addr, fail_data); end
        n_cmp++; if (store_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_store_cnt got %0d want 0", store_cnt); end
    endtask

    task automatic test_pass_with_skip();
        do_reset();
        load(0, 84, 7);
        ign_en = 1'b1; ign_addr = 32'd80;
        do_start(1);
        store(80, 32'h1111);
        store(80, 32'h2222);
        n_cmp++; if (status !== 2'b00 || done !== 1'b0) begin n_bad++; $display("FAIL skip_running got %0b/%0b want 00/0", status, done); end
        store(84, 7);
        n_cmp++; if (status !== 2'b01) begin n_bad++; $display("FAIL pass_status got %0b want 01", status); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL pass_done got %0b want 1", done); end
        n_cmp++; if (match_idx !== 4'd1) begin n_bad++; $display("FAIL pass_match_idx got %0d want 1", match_idx); end
`ifdef MSC_STORE_COUNT_EN
        n_cmp++; if (store_cnt !== 16'd3) begin n_bad++; $display("FAIL store_cnt got %0d want 3", store_cnt); end
`else
        n_cmp++; if (store_cnt !== 16'd0) begin n_bad++; $display("FAIL store_cnt got %0d want 0", store_cnt); end
`endif
        // Terminal state holds; later stores are ignored.
        store(99, 99);
        n_cmp++; if (status !== 2'b01 || fail_addr !== 32'd0) begin n_bad++; $display("FAIL pass_hold got %0b/%0h want 01/0", status, fail_addr); end
        ign_en = 1'b0;
    endtask

    task automatic test_mismatch();
        do_reset();
        load(0, 84, 7);
        ign_en = 1'b1; ign_addr = 32'd80;
        do_start(1);
        store(88, 7);
        n_cmp++; if (status !== 2'b10 || done !== 1'b1) begin n_bad++; $display("FAIL mm_status got %0b/%0b want 10/1", status, done); end
        n_cmp++; if (fail_addr !== 32'd88) begin n_bad++; $display("FAIL mm_fail_addr got %0d want 88", fail_addr); end
        n_cmp++; if (fail_data !== 32'd7) begin n_bad++; $display("FAIL mm_fail_data got %0d want 7", fail_data); end
        n_cmp++; if (match_idx !== 4'd0) begin n_bad++; $display("FAIL mm_match_idx got %0d want 0", match_idx); end
        ign_en = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        load(0, 84, 7);
        do_start(1);
        repeat (15) tick();
        n_cmp++; if (status !== 2'b00) begin n_bad++; $display("FAIL tmo_early got %0b want 00", status); end
        tick();
        n_cmp++; if (status !== 2'b11 || done !== 1'b1) begin n_bad++; $display("FAIL tmo_status got %0b/%0b want 11/1", status, done); end
    endtask

    task automatic test_match_beats_timeout();
        do_reset();
        load(0, 84, 7);
        do_start(1);
        repeat (15) tick();
        store(84, 7);
        n_cmp++; if (status !== 2'b01) begin n_bad++; $display("FAIL tmo_vs_match got %0b want 01", status); end
    endtask

    task automatic test_order_and_rearm();
        do_reset();
        load(0, 0, 1);
        load(1, 4, 2);
        load(2, 8, 3);
        do_start(3);
        store(4, 2);
        n_cmp++; if (status !== 2'b10 || fail_addr !== 32'd4) begin n_bad++; $display("FAIL order_fail got %0b/%0d want 10/4", status, fail_addr); end
        do_start(3);
        n_cmp++; if (status !== 2'b00 || done !== 1'b0 || fail_addr !== 32'd0) begin n_bad++; $display("FAIL rearm_clear got %0b/%0b/%0d want 00/0/0", status, done, fail_addr); end
        store(0, 1);
        n_cmp++; if (match_idx !== 4'd1 || status !== 2'b00) begin n_bad++; $display("FAIL rearm_mid got %0d/%0b want 1/00", match_idx, status); end
        store(4, 2);
        store(8, 3);
        n_cmp++; if (status !== 2'b01 || match_idx !== 4'd3) begin n_bad++; $display("FAIL rearm_pass got %0b/%0d want 01/3", status, match_idx); end
    endtask

    task automatic test_zero_cnt_and_abort();
        do_reset();
        do_start(0);
        n_cmp++; if (status !== 2'b01 || done !== 1'b1 || match_idx !== 4'd0) begin n_bad++; $display("FAIL zero_cnt got %0b/%0b/%0d want 01/1/0", status, done, match_idx); end
        do_reset();
        load(0, 0, 1);
        load(1, 4, 2);
        do_start(2);
        store(0, 1);
        n_cmp++; if (match_idx !== 4'd1) begin n_bad++; $display("FAIL abort_pre got %0d want 1", match_idx); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (match_idx !== 4'd0 || status !== 2'b00 || done !== 1'b0) begin n_bad++; $display("FAIL abort_post got %0d/%0b/%0b want 0/00/0", match_idx, status, done); end
        // Back in IDLE: a store is not checked.
        store(4, 2);
        n_cmp++; if (match_idx !== 4'd0 || status !== 2'b00) begin n_bad++; $display("FAIL idle_store got %0d/%0b want 0/00", match_idx, status); end
    endtask

    task automatic test_we_with_start();
        do_reset();
        exp_we = 1'b1; exp_idx = 4'd0; exp_addr = 32'd20; exp_data = 32'd5;
        do_start(1);
        exp_we = 1'b0;
        store(20, 5);
        n_cmp++; if (status !== 2'b01) begin n_bad++; $display("FAIL we_with_start got %0b want 01", status); end
    endtask

    task automatic test_clamp();
        do_reset();
        for (int i = 0; i < DEPTH; i++) load(i, 4 * i + 256, i + 100);
        do_start(15);
        for (int i = 0; i < DEPTH - 1; i++) store(4 * i + 256, i + 100);
        n_cmp++; if (status !== 2'b00 || match_idx !== 4'd7) begin n_bad++; $display("FAIL clamp_mid got %0b/%0d want 00/7", status, match_idx); end
        store(4 * (DEPTH - 1) + 256, DEPTH - 1 + 100);
        n_cmp++; if (status !== 2'b01 || match_idx !== 4'd8) begin n_bad++; $display("FAIL clamp_pass got %0b/%0d want 01/8", status, match_idx); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
        exp_cnt = '0; ign_en = 1'b0; ign_addr = '0; start = 1'b0;
        memwrite = 1'b0; dataadr = '0; writedata = '0;
        test_reset();
        test_pass_with_skip();
        test_mismatch();
        test_timeout();
        test_match_beats_timeout();
        test_order_and_rearm();
        test_zero_cnt_and_abort();
        test_we_with_start();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
